// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter_if
// Brief   : Requester and register-file write-port bundle for the WB arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              pipe_wb_en;
    logic [ADDR_W-1:0] pipe_wb_dest;
    logic [DATA_W-1:0] pipe_wb_data;
    logic              mc_valid;
    logic [ADDR_W-1:0] mc_dest;
    logic [DATA_W-1:0] mc_data;
    logic              mc_ready;
    logic              pipe_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_dest;
    logic [DATA_W-1:0] rf_data;
    logic              init_busy;

    // Requester side: WB stage, multi-cycle unit and the register file sink.
    modport master (
        output pipe_wb_en, pipe_wb_dest, pipe_wb_data,
        output mc_valid, mc_dest, mc_data,
        input  mc_ready, pipe_stall,
        input  rf_we, rf_dest, rf_data, init_busy
    );

    modport slave (
        input  pipe_wb_en, pipe_wb_dest, pipe_wb_data,
        input  mc_valid, mc_dest, mc_data,
        output mc_ready, pipe_stall,
        output rf_we, rf_dest, rf_data, init_busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Shares the register-file write port between the pipeline WB stage
//           (priority) and a multi-cycle unit (valid/ready), with an
//           anti-starvation forced grant. Optional macro REGFILE_INIT_SEQ_EN
//           adds a post-reset sequencer writing R[i]=i.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int NUM_REGS   = 15,
    parameter int STARVE_MAX = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int              c_CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W:0] c_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [c_CNT_W-1:0] r_starve;
    logic               w_init;
    logic               w_force;
    logic               w_mc_ready;
    logic               w_pipe_stall;
    logic               w_mc_xfer;
    logic               w_pipe_xfer;
    logic               w_mc_ok;
    logic               w_pipe_ok;

`ifdef REGFILE_INIT_SEQ_EN
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;

    assign w_init = (r_state == ST_INIT);
`else
    assign w_init = 1'b0;
`endif

    assign w_force = bus.mc_valid && (r_starve == c_CNT_W'(STARVE_MAX));

    always_comb begin
        w_mc_ready   = 1'b1;
        w_pipe_stall = 1'b0;
        if (w_init) begin
            w_mc_ready   = 1'b0;
            w_pipe_stall = 1'b1;
        end else if (w_force) begin
            w_pipe_stall = bus.pipe_wb_en;
        end else if (bus.pipe_wb_en) begin
            w_mc_ready   = 1'b0;
        end
    end

    assign w_mc_xfer   = bus.mc_valid && w_mc_ready;
    assign w_pipe_xfer = bus.pipe_wb_en && !w_pipe_stall;
    // Out-of-range destinations still complete the handshake but never write.
    assign w_mc_ok     = ({1'b0, bus.mc_dest} < c_LIMIT);
    assign w_pipe_ok   = ({1'b0, bus.pipe_wb_dest} < c_LIMIT);

    assign bus.mc_ready   = w_mc_ready;
    assign bus.pipe_stall = w_pipe_stall;
    assign bus.init_busy  = w_init;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve    <= '0;
            bus.rf_we   <= 1'b0;
            bus.rf_dest <= '0;
            bus.rf_data <= '0;
`ifdef REGFILE_INIT_SEQ_EN
            r_state     <= ST_INIT;
            r_idx       <= '0;
`endif
        end else begin
            if (bus.mc_valid && !w_mc_ready) begin
                if (r_starve != c_CNT_W'(STARVE_MAX))
                    r_starve <= r_starve + c_CNT_W'(1);
            end else begin
                r_starve <= '0;
            end

`ifdef REGFILE_INIT_SEQ_EN
            if (r_state == ST_INIT) begin
                bus.rf_we   <= 1'b1;
                bus.rf_dest <= r_idx;
                bus.rf_data <= DATA_W'(r_idx);
                if (r_idx == c_LAST_IDX)
                    r_state <= ST_RUN;
                else
                    r_idx <= r_idx + ADDR_W'(1);
            end else
`endif
            if (w_mc_xfer) begin
                bus.rf_we <= w_mc_ok;
                if (w_mc_ok) begin
                    bus.rf_dest <= bus.mc_dest;
                    bus.rf_data <= bus.mc_data;
                end
            end else if (w_pipe_xfer) begin
                bus.rf_we <= w_pipe_ok;
                if (w_pipe_ok) begin
                    bus.rf_dest <= bus.pipe_wb_dest;
                    bus.rf_data <= bus.pipe_wb_data;
                end
            end else begin
                bus.rf_we <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Directed and randomized self-checking bench for regfile_wb_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 4;
    localparam int NUM_REGS   = 15;
    localparam int STARVE_MAX = 4;
`ifdef REGFILE_INIT_SEQ_EN
    localparam int INIT_CYCLES = NUM_REGS;
`else
    localparam int INIT_CYCLES = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .NUM_REGS(NUM_REGS), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: denied-cycle count, remaining init writes, expected port.
    int          m_starve;
    int          m_init_left;
    int          m_idx;
    logic        m_we;
    logic [31:0] m_dest;
    logic [31:0] m_data;
    logic        m_pipe_stalled;
    logic        m_mc_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_starve       = 0;
        m_init_left    = INIT_CYCLES;
        m_idx          = 0;
        m_we           = 1'b0;
        m_dest         = 0;
        m_data         = 0;
        m_pipe_stalled = 1'b0;
        m_mc_done      = 1'b0;
    endtask

    task automatic record_write(input logic [31:0] dest, input logic [31:0] data);
        if (dest < NUM_REGS) begin
            m_we   = 1'b1;
            m_dest = dest;
            m_data = data;
        end else begin
            m_we   = 1'b0;
        end
    endtask

    // One clock: check combinational grants at negedge, registered port after posedge.
    task automatic cycle();
        bit in_init, starved, e_rdy, e_stl, mc_go, pipe_go;
        @(negedge clk);
        in_init = (m_init_left > 0);
        starved = bus.mc_valid && (m_starve == STARVE_MAX);
        if (in_init)             begin e_rdy = 1'b0; e_stl = 1'b1; end
        else if (starved)        begin e_rdy = 1'b1; e_stl = bus.pipe_wb_en; end
        else if (bus.pipe_wb_en) begin e_rdy = 1'b0; e_stl = 1'b0; end
        else                     begin e_rdy = 1'b1; e_stl = 1'b0; end
        chk("mc_ready",   32'(bus.mc_ready),   32'(e_rdy));
        chk("pipe_stall", 32'(bus.pipe_stall), 32'(e_stl));
        chk("init_busy",  32'(bus.init_busy),  32'(in_init));
        mc_go   = bus.mc_valid && e_rdy;
        pipe_go = bus.pipe_wb_en && !e_stl;
        if (bus.mc_valid && !e_rdy) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
        else                        m_starve = 0;
        if (in_init) begin
            m_we   = 1'b1;
            m_dest = m_idx;
            m_data = m_idx;
            m_idx++;
            m_init_left--;
        end else if (mc_go)   record_write(32'(bus.mc_dest), bus.mc_data);
        else if (pipe_go)     record_write(32'(bus.pipe_wb_dest), bus.pipe_wb_data);
        else                  m_we = 1'b0;
        m_mc_done      = mc_go;
        m_pipe_stalled = bus.pipe_wb_en && e_stl;
        @(posedge clk);
        #1;
        chk("rf_we",   32'(bus.rf_we),   32'(m_we));
        chk("rf_dest", 32'(bus.rf_dest), m_dest);
        chk("rf_data", bus.rf_data,      m_data);
    endtask

    task automatic set_pipe(input logic en, input logic [3:0] dest, input logic [31:0] data);
        bus.pipe_wb_en = en; bus.pipe_wb_dest = dest; bus.pipe_wb_data = data;
    endtask

    task automatic set_mc(input logic v, input logic [3:0] dest, input logic [31:0] data);
        bus.mc_valid = v; bus.mc_dest = dest; bus.mc_data = data;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        set_pipe(1'b0, 4'd0, 32'd0);
        set_mc(1'b0, 4'd0, 32'd0);
        #1;
        chk("rst_rf_we",   32'(bus.rf_we),   32'd0);
        chk("rst_rf_dest", 32'(bus.rf_dest), 32'd0);
        chk("rst_rf_data", bus.rf_data,      32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        set_pipe(1'b0, 4'd0, 32'd0);
        set_mc(1'b0, 4'd0, 32'd0);
        @(posedge clk);
        apply_reset();

`ifdef REGFILE_INIT_SEQ_EN
        // Reset mid-init at idx 7, then a full init run.
        repeat (7) cycle();
        rst = 1'b1;
        #1;
        chk("midinit_rf_we",   32'(bus.rf_we),   32'd0);
        chk("midinit_rf_dest", 32'(bus.rf_dest), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle();
        chk("restart_dest0", 32'(bus.rf_dest), 32'd0);
        repeat (NUM_REGS - 1) cycle();
        chk("init_last_dest", 32'(bus.rf_dest), 32'(NUM_REGS - 1));
        #1;
        chk("init_done", 32'(bus.init_busy), 32'd0);
`else
        // First cycle after release is already RUN.
        set_pipe(1'b1, 4'd1, 32'd9);
        cycle();
        chk("first_cycle_we",   32'(bus.rf_we),   32'd1);
        chk("first_cycle_data", bus.rf_data,      32'd9);
`endif

        // Plain pipeline write.
        set_pipe(1'b1, 4'd3, 32'hDEAD);
        set_mc(1'b0, 4'd0, 32'd0);
        cycle();
        chk("pipe_dest", 32'(bus.rf_dest), 32'd3);
        chk("pipe_data", bus.rf_data,      32'hDEAD);

        // Starvation: pipe wins STARVE_MAX cycles, then mc is forced.
        set_pipe(1'b1, 4'd5, 32'h1111);
        set_mc(1'b1, 4'd6, 32'h2222);
        repeat (STARVE_MAX) cycle();
        chk("starve_pipe_won", 32'(bus.rf_dest), 32'd5);
        #1;
        chk("force_ready", 32'(bus.mc_ready),   32'd1);
        chk("force_stall", 32'(bus.pipe_stall), 32'd1);
        cycle();
        chk("force_mc_data", bus.rf_data, 32'h2222);
        set_mc(1'b0, 4'd0, 32'd0);
        cycle();
        chk("after_force_pipe", bus.rf_data, 32'h1111);

        // Unwritable mc destination is consumed without a write.
        set_pipe(1'b0, 4'd0, 32'd0);
        set_mc(1'b1, 4'd15, 32'h55);
        cycle();
        chk("dest15_no_we", 32'(bus.rf_we), 32'd0);
        set_mc(1'b1, 4'd2, 32'h77);
        cycle();
        chk("next_mc_we", 32'(bus.rf_we), 32'd1);
        set_mc(1'b0, 4'd0, 32'd0);
        cycle();

        // Randomized traffic obeying the hold rules of both requesters.
        for (int i = 0; i < 400; i++) begin
            if (!m_pipe_stalled)
                set_pipe(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom);
            if (!bus.mc_valid || m_mc_done)
                set_mc(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), $urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
